lane_merger: RTL

Parametrised N-lane to single-stream merger for the PCI lane datapath. It accepts one beat of `LANES` parallel bytes with per-lane valid flags and replays the valid lanes onto one output stream, one lane per cycle, tagged with the lane index. It generalises the fixed 4-lane, selector-driven mux to arbitrary lane count and data width, on a single clock with ready/valid backpressure. Two modes are supported: fixed cadence, which keeps slots for invalid lanes, and compact, which skips invalid lanes.

---
 rtl/lane_merger_pkg.sv | 15 +
 rtl/lane_merger_pick.sv | 22 ++
 rtl/lane_merger.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lane_merger_pkg.sv
// Shared types and helpers for the lane merger and its lane picker.
package lane_merger_pkg;

  // IDLE: no beat held. SEND: a captured beat is being replayed slot by slot.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } merger_state_t;

  // Index width for an n-entry lane set; never narrower than one bit.
  function automatic int lane_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_merger_pick.sv
// Lowest-set-bit priority encoder used to choose the next pending lane.
module lane_pick
  import lane_merger_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = lane_bits(N)
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/lane_merger.sv
// Merges one beat of LANES parallel lanes onto a single output stream,
// one lane per slot, tagged with its source lane index.
//
// Handshake: a beat is taken on a rising edge where in_ready && |in_valid;
// a slot is taken where out_valid && out_ready. While out_valid is high and
// out_ready low, every out_* signal holds. in_ready depends only on state
// and out_ready, never on in_valid. In fixed-cadence mode an empty lane
// still occupies a one-cycle slot (out_valid low) that needs no out_ready.
module lane_merger
  import lane_merger_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int WIDTH   = 8,
  parameter int COMPACT = 0,
  parameter int LW      = lane_bits(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [LW-1:0]          out_lane,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [15:0]            beat_count,
  output logic                   stateDbg
);

  merger_state_t          state;
  logic [LANES*WIDTH-1:0] bufData;
  logic [LANES-1:0]       pend;
  logic [LW-1:0]          ptr;
  logic [15:0]            beatCount;

  logic [LW-1:0]          pickIdx;
  logic                   pickAny;
  logic [LW-1:0]          selLane;
  logic                   slotValid;
  logic                   slotLast;
  logic                   slotDone;
  logic                   accept;
  logic [LANES-1:0]       clearMask;
  logic [WIDTH-1:0]       laneData;

  lane_pick #(
    .N  (LANES),
    .IW (LW)
  ) uPick (
    .mask (pend),
    .idx  (pickIdx),
    .any  (pickAny)
  );

  // Decode the current slot from held state: which lane, whether it carries data, whether it ends the beat.
  always_comb begin
    selLane   = '0;
    slotValid = 1'b0;
    slotLast  = 1'b0;
    if (state == SEND) begin
      if (COMPACT != 0) begin
        selLane   = pickIdx;
        slotValid = pickAny;
        slotLast  = ($countones(pend) == 1);
      end else begin
        selLane   = ptr;
        slotValid = pend[ptr];
        slotLast  = (ptr == LW'(LANES - 1));
      end
    end
  end

  // One-hot of the lane being presented, used to retire it from the pending mask.
  always_comb begin
    clearMask          = '0;
    clearMask[selLane] = 1'b1;
  end

  assign laneData = bufData[int'(selLane)*WIDTH +: WIDTH];

  // Empty fixed-cadence slots complete on their own; data slots need the downstream handshake.
  assign slotDone = (state == SEND) &&
                    ((slotValid && out_ready) || ((COMPACT == 0) && !slotValid));
  assign in_ready = (state == IDLE) || (slotLast && slotDone);
  assign accept   = in_ready && (|in_valid);

  assign out_valid  = slotValid;
  assign out_data   = slotValid ? laneData : '0;
  assign out_lane   = selLane;
  assign out_last   = slotLast;
  assign beat_count = beatCount;
  assign stateDbg   = (state == SEND);

  // Beat capture, slot advance and return to IDLE; a new beat on the last slot reloads without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bufData   <= '0;
      pend      <= '0;
      ptr       <= '0;
      beatCount <= '0;
    end else if (accept) begin
      state     <= SEND;
      bufData   <= in_data;
      pend      <= in_valid;
      ptr       <= '0;
      beatCount <= beatCount + 16'd1;
    end else if (slotDone) begin
      if (slotLast) begin
        state <= IDLE;
        pend  <= '0;
        ptr   <= '0;
      end else begin
        pend <= pend & ~clearMask;
        ptr  <= ptr + LW'(1);
      end
    end
  end

endmodule
